perceptron_feeder: RTL and testbench

//  Initiator side of the perceptron en/ready interface: holds a labelled sample set
//  (pattern + expected class), presents each pattern to the perceptron and waits for ready.

---
 rtl/perceptron_feeder.sv | 160 ++++++++++++++++
 tb/tb_perceptron_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_feeder.sv
// Initiator for the perceptron en/ready interface. It presents each stored labelled
// pattern, captures the class/accumulator result and keeps per-run match/error tallies.
module perceptron_feeder #(
    parameter int WIDTH    = 25,
    parameter int SET_SIZE = 20,
    parameter int MIN_HOLD = 6,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 255,
    localparam int AW      = $clog2(SET_SIZE),
    localparam int ACC_W   = $clog2(WIDTH),
    localparam int CW      = $clog2(SET_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH+1:0] wr_data,
    input  logic             start,
    output logic [WIDTH-1:0] p_in,
    output logic             p_en,
    input  logic             p_ready,
    input  logic [1:0]       p_out,
    input  logic [ACC_W-1:0] p_acc,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic [AW-1:0]    res_idx,
    output logic [1:0]       res_out,
    output logic [ACC_W-1:0] res_acc,
    output logic             res_match,
    output logic [CW-1:0]    match_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic             timeout,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH+1:0] mem [SET_SIZE];
    logic [AW-1:0]    idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       label_q;
    logic [1:0]       res_out_q;
    logic [ACC_W-1:0] res_acc_q;
    logic             to_q;
    logic             accept;
    logic             wait_expired;
    logic             gap_end;
    logic             sample_match;

    // Handshake: p_en rises with p_in stable and stays high until the result is captured;
    // p_ready is only believed once p_en has been held MIN_HOLD cycles, and is sampled on
    // the edge that ends the WAIT state. p_en drops after CAPTURE and stays low GAP cycles.
    assign accept       = (state_q == S_WAIT) && p_ready && (cnt_q >= CNT_W'(MIN_HOLD));
    assign wait_expired = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign gap_end      = (state_q == S_GAP) && (cnt_q == CNT_W'(GAP - 1));
    assign sample_match = !to_q && (res_out_q == label_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (accept || wait_expired) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_GAP;
            S_GAP: begin
                if (gap_end) state_d = (idx_q == AW'(SET_SIZE - 1)) ? S_DONE : S_ISSUE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Sample memory carries no reset; the loader fills it before the first run.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && ({1'b0, wr_addr} < (AW + 1)'(SET_SIZE)))
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            p_in      <= '0;
            label_q   <= '0;
            res_out_q <= '0;
            res_acc_q <= '0;
            to_q      <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q     <= '0;
                        match_cnt <= '0;
                        err_cnt   <= '0;
                        timeout   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    p_in    <= mem[idx_q][WIDTH-1:0];
                    label_q <= mem[idx_q][WIDTH+1:WIDTH];
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (accept) begin
                        res_out_q <= p_out;
                        res_acc_q <= p_acc;
                        to_q      <= 1'b0;
                    end else if (wait_expired) begin
                        res_out_q <= '0;
                        res_acc_q <= '0;
                        to_q      <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    cnt_q <= '0;
                    if (sample_match) match_cnt <= match_cnt + CW'(1);
                    else              err_cnt   <= err_cnt + CW'(1);
                end
                S_GAP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (gap_end && (idx_q != AW'(SET_SIZE - 1))) idx_q <= idx_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign p_en      = (state_q == S_WAIT) || (state_q == S_CAPTURE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_valid = (state_q == S_CAPTURE);
    assign res_idx   = idx_q;
    assign res_out   = res_out_q;
    assign res_acc   = res_acc_q;
    assign res_match = res_valid && sample_match;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_perceptron_feeder.sv
// Bench for perceptron_feeder: a perceptron responder plus a per-run reference model
// of expected results, counts and timing bounds, checked as results appear.
module tb_perceptron_feeder;

    localparam int WIDTH    = 25;
    localparam int SET_SIZE = 20;
    localparam int MIN_HOLD = 6;
    localparam int GAP      = 4;
    localparam int TIMEOUT  = 255;
    localparam int AW       = 5;
    localparam int ACC_W    = 5;
    localparam int CW       = 5;
    localparam int EW       = AW + 2 + ACC_W + 2;

    // ---------------- clock / reset ----------------
    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH+1:0] wr_data = '0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] p_in;
    logic             p_en;
    logic             p_ready = 1'b0;
    logic [1:0]       p_out = '0;
    logic [ACC_W-1:0] p_acc = '0;
    logic             busy, done, res_valid, res_match, timeout;
    logic [AW-1:0]    res_idx;
    logic [1:0]       res_out;
    logic [ACC_W-1:0] res_acc;
    logic [CW-1:0]    match_cnt, err_cnt;
    logic [2:0]       dbg_state;

    perceptron_feeder dut (
        .clk(clk_tb), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .p_in(p_in), .p_en(p_en), .p_ready(p_ready), .p_out(p_out),
        .p_acc(p_acc), .busy(busy), .done(done), .res_valid(res_valid), .res_idx(res_idx),
        .res_out(res_out), .res_acc(res_acc), .res_match(res_match), .match_cnt(match_cnt),
        .err_cnt(err_cnt), .timeout(timeout), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [WIDTH+1:0] mdl_mem [SET_SIZE];
    int               cfg_d   [SET_SIZE];
    logic [1:0]       cfg_out [SET_SIZE];
    logic [ACC_W-1:0] cfg_acc [SET_SIZE];
    bit               cfg_nr  [SET_SIZE];
    logic [EW-1:0]    exp_q[$];
    int               hold_q[$];
    int               exp_match, exp_err;
    bit               exp_to;
    int               issue_n = 0;
    int               res_seen_run = 0;
    int               done_seen = 0;

    // Expected per-sample outcome from the labelled set and responder behaviour.
    task automatic build_expect();
        int m, e;
        bit to_any;
        exp_q.delete();
        hold_q.delete();
        m = 0; e = 0; to_any = 0;
        for (int i = 0; i < SET_SIZE; i++) begin
            bit tmo, mt;
            logic [1:0] o;
            logic [ACC_W-1:0] a;
            tmo = cfg_nr[i];
            o   = tmo ? 2'd0 : cfg_out[i];
            a   = tmo ? '0 : cfg_acc[i];
            mt  = !tmo && (o == mdl_mem[i][WIDTH+1:WIDTH]);
            to_any = to_any | tmo;
            if (mt) m++; else e++;
            exp_q.push_back({AW'(i), o, a, mt, to_any});
            hold_q.push_back(tmo ? TIMEOUT : ((cfg_d[i] > MIN_HOLD) ? cfg_d[i] : MIN_HOLD));
        end
        exp_match = m;
        exp_err   = e;
        exp_to    = to_any;
    endtask

    task automatic random_cfg();
        for (int i = 0; i < SET_SIZE; i++) begin
            cfg_d[i]   = $urandom_range(0, 12);
            cfg_nr[i]  = 1'b0;
            cfg_acc[i] = ACC_W'($urandom_range(0, 31));
            cfg_out[i] = ($urandom_range(0, 1) == 1) ? mdl_mem[i][WIDTH+1:WIDTH]
                                                     : 2'($urandom_range(0, 3));
        end
    endtask

    // ---------------- perceptron responder ----------------
    initial begin
        int age, cur;
        bit prev_en;
        age = 0; cur = 0; prev_en = 0;
        forever begin
            @(posedge clk_tb);
            #1;
            if (p_en && !prev_en) begin
                cur = issue_n % SET_SIZE;
                issue_n++;
                age = 0;
            end else if (p_en) begin
                age++;
            end
            prev_en = p_en;
            if (p_en) begin
                p_out   = cfg_out[cur];
                p_acc   = cfg_acc[cur];
                p_ready = !cfg_nr[cur] && (age >= cfg_d[cur]);
            end else begin
                p_ready = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        int en_run, low_run, h;
        bit prev;
        logic [EW-1:0] w;
        en_run = 0; low_run = 100; prev = 0;
        forever begin
            @(negedge clk_tb);
            if (p_en) begin
                if (!prev) check_eq("gap_low", low_run >= GAP, 1);
                en_run++;
                low_run = 0;
            end else begin
                en_run = 0;
                low_run++;
            end
            prev = p_en;
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("res_unexpected", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    h = hold_q.pop_front();
                    check_eq("res_idx", res_idx, w[EW-1 -: AW]);
                    check_eq("res_out", res_out, w[ACC_W+3 -: 2]);
                    check_eq("res_acc", res_acc, w[ACC_W+1 -: ACC_W]);
                    check_eq("res_match", res_match, w[1]);
                    check_eq("timeout", timeout, w[0]);
                    check_eq("p_in", p_in, mdl_mem[w[EW-1 -: AW]][WIDTH-1:0]);
                    check_eq("en_hold", (en_run >= h + 1) && (en_run <= h + 2), 1);
                end
                res_seen_run++;
            end
            if (done) begin
                done_seen++;
                check_eq("done_results", res_seen_run, SET_SIZE);
                check_eq("done_match_cnt", match_cnt, exp_match);
                check_eq("done_err_cnt", err_cnt, exp_err);
                check_eq("done_timeout", timeout, exp_to);
                check_eq("done_sum", match_cnt + err_cnt, SET_SIZE);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_entry(input int addr, input logic [WIDTH+1:0] data, input bit lands);
        @(negedge clk_tb);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk_tb);
        wr_en = 1'b0;
        if (lands && addr < SET_SIZE) mdl_mem[addr] = data;
    endtask

    task automatic start_run(input bit with_write, input int addr, input logic [WIDTH+1:0] data);
        @(negedge clk_tb);
        if (with_write) begin
            mdl_mem[addr] = data;
            wr_en   = 1'b1;
            wr_addr = AW'(addr);
            wr_data = data;
        end
        build_expect();
        issue_n      = 0;
        res_seen_run = 0;
        start        = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        wr_en = 1'b0;
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_seen;
        for (int c = 0; c < budget && done_seen == base; c++) @(negedge clk_tb);
        check_eq("done_seen", done_seen - base, 1);
        @(negedge clk_tb);
        check_eq("busy_after_done", busy, 0);
        check_eq("done_pulse_width", done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH+1:0] d5;
        int base_done;

        // reset state
        repeat (3) @(negedge clk_tb);
        check_eq("rst_p_en", p_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_counts", {match_cnt, err_cnt, timeout}, 0);
        check_eq("rst_p_in", p_in, 0);
        check_eq("rst_res", {res_idx, res_out, res_acc, res_match}, 0);
        rst_n = 1'b1;

        // load the set: random entries then the cross / circle / mislabelled cross
        for (int i = 0; i < SET_SIZE; i++)
            write_entry(i, {2'($urandom_range(0, 3)), WIDTH'($urandom)}, 1'b1);
        write_entry(0, {2'd3, 25'h1151151}, 1'b1);
        write_entry(1, {2'd2, 25'h0454544}, 1'b1);
        write_entry(2, {2'd2, 25'h1151151}, 1'b1);
        write_entry(25, {2'd1, 25'h1ffffff}, 1'b0);

        // run A: directed samples 0..4, random remainder
        random_cfg();
        cfg_d[0] = 10; cfg_out[0] = 2'd3; cfg_acc[0] = 5'd11;
        cfg_d[1] = 7;  cfg_out[1] = 2'd2; cfg_acc[1] = 5'd4;
        cfg_d[2] = 8;  cfg_out[2] = 2'd3; cfg_acc[2] = 5'd11;
        cfg_d[3] = 0;
        cfg_nr[4] = 1'b1;
        start_run(1'b0, 0, '0);
        d5 = mdl_mem[5];
        write_entry(5, {~d5[WIDTH+1:WIDTH], ~d5[WIDTH-1:0]}, 1'b0);
        base_done = done_seen;
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        check_eq("start_while_busy", done_seen, base_done);
        wait_done(20000);

        // run C: aborted by reset while sample 7 waits for ready
        random_cfg();
        cfg_d[7] = 12;
        start_run(1'b0, 0, '0);
        for (int c = 0; c < 5000 && !(res_seen_run == 7 && p_en); c++) @(negedge clk_tb);
        check_eq("abort_reached", res_seen_run, 7);
        @(negedge clk_tb);
        base_done = done_seen;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_p_en", p_en, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_counts", {match_cnt, err_cnt}, 0);
        exp_q.delete();
        hold_q.delete();
        repeat (3) @(negedge clk_tb);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_tb);
        check_eq("abort_no_done", done_seen, base_done);
        check_eq("abort_idle", busy, 0);

        // run B: rerun from idx 0 with a write landing on the start cycle
        random_cfg();
        cfg_out[5] = mdl_mem[5][WIDTH+1:WIDTH];
        cfg_nr[$urandom_range(6, 18)] = 1'b1;
        start_run(1'b1, 0, {2'($urandom_range(0, 3)), WIDTH'($urandom)});
        @(negedge clk_tb);
        check_eq("rerun_counts_clear", {match_cnt, err_cnt}, 0);
        wait_done(20000);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
